// File: rtl/xor_scr_pkg.sv
// Shared definitions for the 16-bit XOR scrambler/descrambler pair.
// The transmit-side scrambler uses the same constants and keystream step, so both ends
// generate an identical keystream from the same seed.
//   WIDTH        data/key width (16 is the only supported value)
//   POLY         Galois feedback mask for x^16+x^14+x^13+x^11+1
//   SEED_DEFAULT key used at reset and in place of an all-zero seed
package xor_scr_pkg;

    localparam int unsigned       WIDTH        = 16;
    localparam logic [WIDTH-1:0]  POLY         = 16'hB400;
    localparam logic [WIDTH-1:0]  SEED_DEFAULT = 16'hACE1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // One Galois LFSR step: shift right, fold the polynomial back in when bit 0 falls out.
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] k);
        return (k >> 1) ^ (k[0] ? POLY : '0);
    endfunction

    // The all-zero state is a fixed point of the LFSR, so it is never allowed as a key.
    function automatic logic [WIDTH-1:0] seed_fix(input logic [WIDTH-1:0] s);
        return (s == '0) ? SEED_DEFAULT : s;
    endfunction

endpackage

// File: rtl/XorGate16.sv
// 16-bit bitwise XOR, the shared datapath primitive of the scrambler pair.
//   a, b  operands
//   y     a ^ b
module XorGate16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);

    assign y = a ^ b;

endmodule

// File: rtl/xor_key_lfsr.sv
// Keystream key register for the descrambler.
// Holds the current key, loads a new seed (zero mapped to SEED_DEFAULT) or steps the LFSR
// once per consumed word. A load takes priority over a step in the same cycle.
//   clk, rst_n  clock and asynchronous active-low reset (key returns to SEED_DEFAULT)
//   load        load seed into the key this cycle
//   seed        seed value sampled on load
//   advance     step the key this cycle (ignored when load is set)
//   key         current key, registered
module xor_key_lfsr
    import xor_scr_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             advance,
    output logic [WIDTH-1:0] key
);

    logic [WIDTH-1:0] key_q;
    logic [WIDTH-1:0] key_d;

    always_comb begin
        key_d = key_q;
        if (load) begin
            key_d = seed_fix(seed);
        end else if (advance) begin
            key_d = lfsr_step(key_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q <= SEED_DEFAULT;
        end else begin
            key_q <= key_d;
        end
    end

    assign key = key_q;

endmodule

// File: rtl/xor_descrambler16.sv
// Receive-side 16-bit XOR descrambler.
// Each accepted word is XORed with the running LFSR key to recover plaintext; the key steps
// once per accepted word. A seed_load pulse (re)synchronises the keystream and moves the
// block from IDLE to RUN. One-cycle latency, one word per cycle throughput.
//   clk, rst_n           clock and asynchronous active-low reset
//   seed_load, seed      keystream (re)seed pulse and value
//   in_valid/in_ready    scrambled word handshake, in_data the word
//   out_valid/out_ready  descrambled word handshake, out_data the registered word
//   word_cnt             words accepted since the last seed_load (wraps)
//   synced               high while in RUN
module xor_descrambler16
    import xor_scr_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [15:0]      word_cnt,
    output logic             synced
);

    state_e           state_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [15:0]      word_cnt_q;
    logic [WIDTH-1:0] key;
    logic [WIDTH-1:0] plain;
    logic             accept;

    // Output slot is free when empty or being drained this cycle.
    assign in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    xor_key_lfsr u_key (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (seed_load),
        .seed    (seed),
        .advance (accept),
        .key     (key)
    );

    XorGate16 u_xor (
        .a (in_data),
        .b (key),
        .y (plain)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            word_cnt_q  <= '0;
        end else begin
            if (seed_load) begin
                state_q <= RUN;
            end

            if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= plain;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            // A re-seed restarts the count even when it coincides with an accept.
            if (seed_load) begin
                word_cnt_q <= '0;
            end else if (accept) begin
                word_cnt_q <= word_cnt_q + 16'd1;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign word_cnt  = word_cnt_q;
    assign synced    = (state_q == RUN);

endmodule
